// File: rtl/pi_switch_vc_alloc.sv
// Registered BFT pi switch with per-direction virtual channels: a separable
// round-robin allocator (VC stage, then output stage) feeds one-entry output registers.
module pi_switch_vc_alloc #(
    parameter int A_W  = 4,
    parameter int D_W  = 8,
    parameter int VC_W = 2,
    localparam int PW  = A_W + D_W + 1,
    localparam int VW  = (VC_W > 1) ? $clog2(VC_W) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [VC_W-1:0]      l_in_valid,
    input  logic [2*VC_W-1:0]    l_in_dir,
    input  logic [VC_W*PW-1:0]   l_in_packet,
    output logic [VC_W-1:0]      l_in_ready,
    output logic                 l_out_valid,
    output logic [VW-1:0]        l_out_vc,
    output logic [PW-1:0]        l_out_packet,
    input  logic                 l_out_ready,
    input  logic [VC_W-1:0]      r_in_valid,
    input  logic [2*VC_W-1:0]    r_in_dir,
    input  logic [VC_W*PW-1:0]   r_in_packet,
    output logic [VC_W-1:0]      r_in_ready,
    output logic                 r_out_valid,
    output logic [VW-1:0]        r_out_vc,
    output logic [PW-1:0]        r_out_packet,
    input  logic                 r_out_ready,
    input  logic [VC_W-1:0]      u0_in_valid,
    input  logic [2*VC_W-1:0]    u0_in_dir,
    input  logic [VC_W*PW-1:0]   u0_in_packet,
    output logic [VC_W-1:0]      u0_in_ready,
    output logic                 u0_out_valid,
    output logic [VW-1:0]        u0_out_vc,
    output logic [PW-1:0]        u0_out_packet,
    input  logic                 u0_out_ready,
    input  logic [VC_W-1:0]      u1_in_valid,
    input  logic [2*VC_W-1:0]    u1_in_dir,
    input  logic [VC_W*PW-1:0]   u1_in_packet,
    output logic [VC_W-1:0]      u1_in_ready,
    output logic                 u1_out_valid,
    output logic [VW-1:0]        u1_out_vc,
    output logic [PW-1:0]        u1_out_packet,
    input  logic                 u1_out_ready,
    output logic                 err_illegal_route
);

    // Direction codes: 0=L, 1=R, 2=U0, 3=U1. Up links may only turn down.
    function automatic logic legal(input logic [1:0] src, input logic [1:0] dst);
        case (src)
            2'd0:    legal = (dst != 2'd0);
            2'd1:    legal = (dst != 2'd1);
            default: legal = !dst[1];
        endcase
    endfunction

    logic [VC_W-1:0] in_valid [4];
    logic [1:0]      in_dir   [4][VC_W];
    logic [PW-1:0]   in_pkt   [4][VC_W];
    logic [VC_W-1:0] in_ready [4];
    logic [3:0]      out_ready;

    logic [3:0]      o_valid_q, o_valid_d;
    logic [VW-1:0]   o_vc_q   [4], o_vc_d   [4];
    logic [PW-1:0]   o_pkt_q  [4], o_pkt_d  [4];
    logic [VW-1:0]   in_ptr_q [4], in_ptr_d [4];
    logic [1:0]      out_ptr_q[4], out_ptr_d[4];
    logic            err_q, err_d;

    logic [3:0]      free_s, nom_valid, grant_valid, win;
    logic [VW-1:0]   nom_vc   [4];
    logic [1:0]      nom_dir  [4];
    logic [1:0]      grant_in [4];
    logic            illegal_seen;

    // Unpack the flat per-direction buses into indexable arrays.
    always_comb begin
        in_valid[0] = l_in_valid;
        in_valid[1] = r_in_valid;
        in_valid[2] = u0_in_valid;
        in_valid[3] = u1_in_valid;
        out_ready   = {u1_out_ready, u0_out_ready, r_out_ready, l_out_ready};
        for (int v = 0; v < VC_W; v++) begin
            in_dir[0][v] = l_in_dir[2*v +: 2];
            in_dir[1][v] = r_in_dir[2*v +: 2];
            in_dir[2][v] = u0_in_dir[2*v +: 2];
            in_dir[3][v] = u1_in_dir[2*v +: 2];
            in_pkt[0][v] = l_in_packet[PW*v +: PW];
            in_pkt[1][v] = r_in_packet[PW*v +: PW];
            in_pkt[2][v] = u0_in_packet[PW*v +: PW];
            in_pkt[3][v] = u1_in_packet[PW*v +: PW];
        end
    end

    // Separable allocation: VC nominee per input, then one winning input per output.
    always_comb begin
        logic [VW:0]   sum;
        logic [VW-1:0] idx;
        logic [1:0]    src;
        free_s       = ~o_valid_q | out_ready;
        illegal_seen = 1'b0;
        win          = 4'b0000;
        for (int d = 0; d < 4; d++) begin
            nom_valid[d] = 1'b0;
            nom_vc[d]    = '0;
            nom_dir[d]   = 2'd0;
            for (int k = 0; k < VC_W; k++) begin
                sum = {1'b0, in_ptr_q[d]} + (VW+1)'(k);
                if (sum >= (VW+1)'(VC_W)) begin
                    sum = sum - (VW+1)'(VC_W);
                end else begin
                    sum = sum;
                end
                idx = sum[VW-1:0];
                if (in_valid[d][idx] && !legal(2'(d), in_dir[d][idx])) begin
                    illegal_seen = 1'b1;
                end else begin
                    illegal_seen = illegal_seen;
                end
                if (!nom_valid[d] && in_valid[d][idx] && legal(2'(d), in_dir[d][idx])
                    && free_s[in_dir[d][idx]]) begin
                    nom_valid[d] = 1'b1;
                    nom_vc[d]    = idx;
                    nom_dir[d]   = in_dir[d][idx];
                end else begin
                    nom_valid[d] = nom_valid[d];
                end
            end
        end
        for (int o = 0; o < 4; o++) begin
            grant_valid[o] = 1'b0;
            grant_in[o]    = 2'd0;
            for (int k = 0; k < 4; k++) begin
                src = out_ptr_q[o] + 2'(k);
                if (!grant_valid[o] && nom_valid[src] && (nom_dir[src] == 2'(o))) begin
                    grant_valid[o] = 1'b1;
                    grant_in[o]    = src;
                end else begin
                    grant_valid[o] = grant_valid[o];
                end
            end
            if (grant_valid[o]) begin
                win[grant_in[o]] = 1'b1;
            end else begin
                win = win;
            end
        end
    end

    // Pop strobes; suppressed while reset is asserted.
    always_comb begin
        for (int d = 0; d < 4; d++) begin
            in_ready[d] = '0;
            if (win[d] && !rst) begin
                in_ready[d][nom_vc[d]] = 1'b1;
            end else begin
                in_ready[d] = '0;
            end
        end
    end

    // Next state for output registers, round-robin pointers and the sticky error.
    always_comb begin
        err_d = err_q | illegal_seen;
        for (int o = 0; o < 4; o++) begin
            if (grant_valid[o]) begin
                o_valid_d[o] = 1'b1;
                o_vc_d[o]    = nom_vc[grant_in[o]];
                o_pkt_d[o]   = in_pkt[grant_in[o]][nom_vc[grant_in[o]]];
                out_ptr_d[o] = grant_in[o] + 2'd1;
            end else begin
                o_valid_d[o] = o_valid_q[o] & ~out_ready[o];
                o_vc_d[o]    = o_vc_q[o];
                o_pkt_d[o]   = o_pkt_q[o];
                out_ptr_d[o] = out_ptr_q[o];
            end
        end
        for (int d = 0; d < 4; d++) begin
            if (win[d]) begin
                in_ptr_d[d] = (nom_vc[d] == VW'(VC_W - 1)) ? '0 : nom_vc[d] + VW'(1);
            end else begin
                in_ptr_d[d] = in_ptr_q[d];
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid_q <= 4'b0000;
            err_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                o_vc_q[i]    <= '0;
                o_pkt_q[i]   <= '0;
                in_ptr_q[i]  <= '0;
                out_ptr_q[i] <= 2'd0;
            end
        end else begin
            o_valid_q <= o_valid_d;
            err_q     <= err_d;
            for (int i = 0; i < 4; i++) begin
                o_vc_q[i]    <= o_vc_d[i];
                o_pkt_q[i]   <= o_pkt_d[i];
                in_ptr_q[i]  <= in_ptr_d[i];
                out_ptr_q[i] <= out_ptr_d[i];
            end
        end
    end

    assign l_in_ready        = in_ready[0];
    assign r_in_ready        = in_ready[1];
    assign u0_in_ready       = in_ready[2];
    assign u1_in_ready       = in_ready[3];
    assign l_out_valid       = o_valid_q[0];
    assign r_out_valid       = o_valid_q[1];
    assign u0_out_valid      = o_valid_q[2];
    assign u1_out_valid      = o_valid_q[3];
    assign l_out_vc          = o_vc_q[0];
    assign r_out_vc          = o_vc_q[1];
    assign u0_out_vc         = o_vc_q[2];
    assign u1_out_vc         = o_vc_q[3];
    assign l_out_packet      = o_pkt_q[0];
    assign r_out_packet      = o_pkt_q[1];
    assign u0_out_packet     = o_pkt_q[2];
    assign u1_out_packet     = o_pkt_q[3];
    assign err_illegal_route = err_q;

endmodule

// File: tb/tb_pi_switch_vc_alloc.sv
// Self-checking bench for pi_switch_vc_alloc: directed scenarios plus randomized
// traffic compared against a queue-based reference model of the allocator rules.
module tb_pi_switch_vc_alloc;
    localparam int A_W  = 4;
    localparam int D_W  = 8;
    localparam int VC_W = 2;
    localparam int PW   = A_W + D_W + 1;
    localparam int VW   = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]    iv  [4];
    logic [1:0]    idr [4][2];
    logic [PW-1:0] ipk [4][2];
    logic [3:0]    ordy;

    logic [1:0]    l_in_ready, r_in_ready, u0_in_ready, u1_in_ready;
    logic          l_out_valid, r_out_valid, u0_out_valid, u1_out_valid;
    logic [VW-1:0] l_out_vc, r_out_vc, u0_out_vc, u1_out_vc;
    logic [PW-1:0] l_out_packet, r_out_packet, u0_out_packet, u1_out_packet;
    logic          err;

    logic [1:0]    irdy [4];
    logic [3:0]    ov;
    logic [VW-1:0] ovc  [4];
    logic [PW-1:0] opk  [4];

    int checks   = 0;
    int failures = 0;

    logic [14:0] fq [4][2][$];

    pi_switch_vc_alloc #(.A_W(A_W), .D_W(D_W), .VC_W(VC_W)) dut (
        .clk(clk), .rst(rst),
        .l_in_valid(iv[0]), .l_in_dir({idr[0][1], idr[0][0]}), .l_in_packet({ipk[0][1], ipk[0][0]}),
        .l_in_ready(l_in_ready), .l_out_valid(l_out_valid), .l_out_vc(l_out_vc),
        .l_out_packet(l_out_packet), .l_out_ready(ordy[0]),
        .r_in_valid(iv[1]), .r_in_dir({idr[1][1], idr[1][0]}), .r_in_packet({ipk[1][1], ipk[1][0]}),
        .r_in_ready(r_in_ready), .r_out_valid(r_out_valid), .r_out_vc(r_out_vc),
        .r_out_packet(r_out_packet), .r_out_ready(ordy[1]),
        .u0_in_valid(iv[2]), .u0_in_dir({idr[2][1], idr[2][0]}), .u0_in_packet({ipk[2][1], ipk[2][0]}),
        .u0_in_ready(u0_in_ready), .u0_out_valid(u0_out_valid), .u0_out_vc(u0_out_vc),
        .u0_out_packet(u0_out_packet), .u0_out_ready(ordy[2]),
        .u1_in_valid(iv[3]), .u1_in_dir({idr[3][1], idr[3][0]}), .u1_in_packet({ipk[3][1], ipk[3][0]}),
        .u1_in_ready(u1_in_ready), .u1_out_valid(u1_out_valid), .u1_out_vc(u1_out_vc),
        .u1_out_packet(u1_out_packet), .u1_out_ready(ordy[3]),
        .err_illegal_route(err)
    );

    always_comb begin
        irdy[0] = l_in_ready;
        irdy[1] = r_in_ready;
        irdy[2] = u0_in_ready;
        irdy[3] = u1_in_ready;
        ov      = {u1_out_valid, u0_out_valid, r_out_valid, l_out_valid};
        ovc[0]  = l_out_vc;
        ovc[1]  = r_out_vc;
        ovc[2]  = u0_out_vc;
        ovc[3]  = u1_out_vc;
        opk[0]  = l_out_packet;
        opk[1]  = r_out_packet;
        opk[2]  = u0_out_packet;
        opk[3]  = u1_out_packet;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        for (int d = 0; d < 4; d++) begin
            iv[d] = 2'b00;
            for (int v = 0; v < 2; v++) begin
                idr[d][v] = 2'd0;
                ipk[d][v] = '0;
            end
        end
        ordy = 4'b0000;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic bit legal_m(int s, int o);
        case (s)
            0:       return (o == 1 || o == 2 || o == 3);
            1:       return (o == 0 || o == 2 || o == 3);
            default: return (o == 0 || o == 1);
        endcase
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        clear_inputs();
        tick();
        for (int o = 0; o < 4; o++) begin
            checks++;
            if ({ov[o], ovc[o], opk[o]} !== {1'b0, 1'b0, 13'h0000}) begin
                failures++;
                $display("FAIL reset_out%0d: got %h expected 0", o, {ov[o], ovc[o], opk[o]});
            end
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL reset_err: got %b expected 0", err);
        end
        rst = 1'b0;
        iv[0] = 2'b01; idr[0][0] = 2'd1; ipk[0][0] = 13'h00AA;
        iv[2] = 2'b01; idr[2][0] = 2'd3;
        ordy = 4'b0000;
        tick();
        tick();
        checks++;
        if ({ov[1], err} !== 2'b11) begin
            failures++;
            $display("FAIL reset_pre_traffic: got valid/err %b expected 11", {ov[1], err});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ov, err, irdy[0]} !== 7'b0000000) begin
            failures++;
            $display("FAIL reset_async: got %b expected 0000000", {ov, err, irdy[0]});
        end
        tick();
        checks++;
        if (irdy[0] !== 2'b00) begin
            failures++;
            $display("FAIL reset_no_ready: got %b expected 00", irdy[0]);
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_single_flow;
        do_reset();
        iv[0] = 2'b10; idr[0][1] = 2'd1; ipk[0][1] = 13'h005A;
        ordy = 4'b0010;
        #1;
        checks++;
        if (irdy[0] !== 2'b10) begin
            failures++;
            $display("FAIL single_ready: got %b expected 10", irdy[0]);
        end
        tick();
        iv[0] = 2'b00;
        checks++;
        if ({r_out_valid, r_out_vc, r_out_packet} !== {1'b1, 1'b1, 13'h005A}) begin
            failures++;
            $display("FAIL single_out: got %h expected %h", {r_out_valid, r_out_vc, r_out_packet},
                     {1'b1, 1'b1, 13'h005A});
        end
        tick();
        checks++;
        if (r_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drain: got %b expected 0", r_out_valid);
        end
    endtask

    task automatic test_contention;
        int sent [4];
        int exp_src;
        logic [PW-1:0] exp_pkt;
        do_reset();
        sent = '{0, 0, 0, 0};
        ordy = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            for (int s = 1; s < 4; s++) begin
                iv[s]     = (sent[s] < 2) ? 2'b01 : 2'b00;
                idr[s][0] = 2'd0;
                ipk[s][0] = 13'(16 * s + sent[s]);
            end
            #1;
            exp_src = 1 + (c % 3);
            for (int s = 1; s < 4; s++) begin
                checks++;
                if (irdy[s] !== ((s == exp_src) ? 2'b01 : 2'b00)) begin
                    failures++;
                    $display("FAIL contention_ready c=%0d in=%0d: got %b", c, s, irdy[s]);
                end
            end
            exp_pkt = 13'(16 * exp_src + c / 3);
            sent[exp_src]++;
            tick();
            checks++;
            if ({ov[0], opk[0]} !== {1'b1, exp_pkt}) begin
                failures++;
                $display("FAIL contention_out c=%0d: got %h expected %h", c, {ov[0], opk[0]}, {1'b1, exp_pkt});
            end
        end
        clear_inputs();
        ordy = 4'b0001;
        tick();
        checks++;
        if (ov[0] !== 1'b0) begin
            failures++;
            $display("FAIL contention_drain: got %b expected 0", ov[0]);
        end
    endtask

    task automatic test_fairness_backpressure;
        logic [PW-1:0] exp_pkt [8];
        logic [VW-1:0] exp_vc  [8];
        int sent0, sent1, acc;
        bit stall;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_pkt[i] = (i % 2 == 0) ? 13'(16'h10 + i / 2) : 13'(16'h20 + i / 2);
            exp_vc[i]  = VW'(i % 2);
        end
        sent0 = 0; sent1 = 0; acc = 0;
        for (int c = 0; c < 30 && acc < 8; c++) begin
            iv[0]     = {sent1 < 4, sent0 < 4};
            idr[0][0] = 2'd2;
            idr[0][1] = 2'd2;
            ipk[0][0] = 13'(16'h10 + sent0);
            ipk[0][1] = 13'(16'h20 + sent1);
            stall     = (c >= 3 && c < 8);
            ordy      = stall ? 4'b0000 : 4'b0100;
            #1;
            if (stall) begin
                checks++;
                if (irdy[0] !== 2'b00) begin
                    failures++;
                    $display("FAIL fair_stall_ready c=%0d: got %b expected 00", c, irdy[0]);
                end
                checks++;
                if ({ov[2], ovc[2], opk[2]} !== {1'b1, exp_vc[acc], exp_pkt[acc]}) begin
                    failures++;
                    $display("FAIL fair_stall_hold c=%0d: got %h expected %h", c,
                             {ov[2], ovc[2], opk[2]}, {1'b1, exp_vc[acc], exp_pkt[acc]});
                end
            end
            if (ov[2] && ordy[2]) begin
                checks++;
                if ({ovc[2], opk[2]} !== {exp_vc[acc], exp_pkt[acc]}) begin
                    failures++;
                    $display("FAIL fair_order n=%0d: got %h expected %h", acc, {ovc[2], opk[2]},
                             {exp_vc[acc], exp_pkt[acc]});
                end
                acc++;
            end
            if (irdy[0][0]) sent0++;
            if (irdy[0][1]) sent1++;
            tick();
        end
        checks++;
        if ({acc, sent0, sent1} !== {32'd8, 32'd4, 32'd4}) begin
            failures++;
            $display("FAIL fair_count: got acc=%0d sent=%0d/%0d expected 8 4/4", acc, sent0, sent1);
        end
        clear_inputs();
    endtask

    task automatic test_parallel_illegal;
        int src_of_out [4];
        do_reset();
        src_of_out = '{2, 3, 0, 1};
        for (int d = 0; d < 4; d++) begin
            iv[d]     = 2'b01;
            ipk[d][0] = 13'(16'h100 + d);
        end
        idr[0][0] = 2'd2; idr[1][0] = 2'd3; idr[2][0] = 2'd0; idr[3][0] = 2'd1;
        ordy = 4'b1111;
        #1;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (irdy[d] !== 2'b01) begin
                failures++;
                $display("FAIL parallel_ready in=%0d: got %b expected 01", d, irdy[d]);
            end
        end
        tick();
        for (int o = 0; o < 4; o++) begin
            checks++;
            if ({ov[o], ovc[o], opk[o]} !== {1'b1, 1'b0, 13'(16'h100 + src_of_out[o])}) begin
                failures++;
                $display("FAIL parallel_out%0d: got %h expected %h", o, {ov[o], ovc[o], opk[o]},
                         {1'b1, 1'b0, 13'(16'h100 + src_of_out[o])});
            end
        end
        clear_inputs();
        iv[2] = 2'b01; idr[2][0] = 2'd3; ipk[2][0] = 13'h0777;
        ordy = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (irdy[2] !== 2'b00) begin
                failures++;
                $display("FAIL illegal_ready c=%0d: got %b expected 00", c, irdy[2]);
            end
            tick();
            checks++;
            if ({err, ov[3]} !== 2'b10) begin
                failures++;
                $display("FAIL illegal_err c=%0d: got err/valid %b expected 10", c, {err, ov[3]});
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL illegal_clear: got %b expected 0", err);
        end
        tick();
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_random;
        int cand [4][3];
        int ncand [4];
        int ptr_in [4];
        int pos_out [4];
        bit mv [4];
        logic [VW-1:0] mvc [4];
        logic [PW-1:0] mpk [4];
        bit free_o [4];
        bit nv [4];
        int nvc [4];
        int nd [4];
        bit gv [4];
        int gs [4];
        int gpos [4];
        logic [1:0] exp_rdy [4];
        logic [1:0] dr;
        int t, v, pos, s;
        do_reset();
        cand[0] = '{1, 2, 3}; cand[1] = '{0, 2, 3}; cand[2] = '{0, 1, 0}; cand[3] = '{0, 1, 0};
        ncand = '{3, 3, 2, 2};
        for (int d = 0; d < 4; d++) begin
            ptr_in[d] = 0; pos_out[d] = 0; mv[d] = 1'b0; mvc[d] = '0; mpk[d] = '0;
            for (int w = 0; w < 2; w++) fq[d][w].delete();
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int d = 0; d < 4; d++) begin
                for (int w = 0; w < 2; w++) begin
                    if ($urandom_range(0, 2) == 0 && fq[d][w].size() < 4) begin
                        t = $urandom_range(0, 2);
                        case (d)
                            0:       dr = 2'(1 + t);
                            1:       dr = (t == 0) ? 2'd0 : 2'(t + 1);
                            default: dr = 2'(t % 2);
                        endcase
                        fq[d][w].push_back({dr, 13'($urandom)});
                    end
                    iv[d][w]  = (fq[d][w].size() > 0);
                    idr[d][w] = (fq[d][w].size() > 0) ? fq[d][w][0][14:13] : 2'd0;
                    ipk[d][w] = (fq[d][w].size() > 0) ? fq[d][w][0][12:0] : 13'h0000;
                end
            end
            ordy = 4'($urandom_range(0, 15));
            #1;
            for (int o = 0; o < 4; o++) free_o[o] = !mv[o] || ordy[o];
            for (int d = 0; d < 4; d++) begin
                nv[d] = 1'b0; nvc[d] = 0; nd[d] = 0;
                for (int k = 0; k < VC_W; k++) begin
                    v = (ptr_in[d] + k) % VC_W;
                    if (!nv[d] && fq[d][v].size() > 0 && legal_m(d, int'(fq[d][v][0][14:13]))
                        && free_o[int'(fq[d][v][0][14:13])]) begin
                        nv[d] = 1'b1; nvc[d] = v; nd[d] = int'(fq[d][v][0][14:13]);
                    end
                end
            end
            for (int d = 0; d < 4; d++) exp_rdy[d] = 2'b00;
            for (int o = 0; o < 4; o++) begin
                gv[o] = 1'b0; gs[o] = 0; gpos[o] = 0;
                for (int k = 0; k < ncand[o]; k++) begin
                    pos = (pos_out[o] + k) % ncand[o];
                    s   = cand[o][pos];
                    if (!gv[o] && nv[s] && nd[s] == o) begin
                        gv[o] = 1'b1; gs[o] = s; gpos[o] = pos;
                    end
                end
                if (gv[o]) exp_rdy[gs[o]] = 2'(1 << nvc[gs[o]]);
            end
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (irdy[d] !== exp_rdy[d]) begin
                    failures++;
                    $display("FAIL random_ready cyc=%0d in=%0d: got %b expected %b", cyc, d, irdy[d], exp_rdy[d]);
                end
            end
            for (int o = 0; o < 4; o++) begin
                if (gv[o]) begin
                    s = gs[o];
                    mv[o]  = 1'b1;
                    mvc[o] = VW'(nvc[s]);
                    mpk[o] = fq[s][nvc[s]][0][12:0];
                    pos_out[o] = (gpos[o] + 1) % ncand[o];
                    ptr_in[s]  = (nvc[s] + 1) % VC_W;
                    void'(fq[s][nvc[s]].pop_front());
                end else if (ordy[o]) begin
                    mv[o] = 1'b0;
                end
            end
            tick();
            for (int o = 0; o < 4; o++) begin
                if (mv[o]) begin
                    checks++;
                    if ({ov[o], ovc[o], opk[o]} !== {1'b1, mvc[o], mpk[o]}) begin
                        failures++;
                        $display("FAIL random_out cyc=%0d out=%0d: got %h expected %h", cyc, o,
                                 {ov[o], ovc[o], opk[o]}, {1'b1, mvc[o], mpk[o]});
                    end
                end else begin
                    checks++;
                    if (ov[o] !== 1'b0) begin
                        failures++;
                        $display("FAIL random_valid cyc=%0d out=%0d: got %b expected 0", cyc, o, ov[o]);
                    end
                end
            end
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL random_err: got %b expected 0", err);
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_flow();
        test_contention();
        test_fairness_backpressure();
        test_parallel_illegal();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
